// File: rtl/delay_arbiter_if.sv
// Request-side bus of the delay arbiter: per-requester strobes, packed
// payloads and the one-hot grant returned by the arbiter.
interface delay_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/delay_arbiter.sv
// Round-robin arbiter feeding a fixed-depth delay pipeline. One requester
// is granted per cycle. Its payload and index then travel N_DELAY stages
// and pop out on out_*. hold freezes everything. flush empties the pipe
// but keeps the round-robin pointer.
module delay_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_DELAY = 4,
    parameter int DATA_W  = 8,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int OCC_W  = $clog2(N_DELAY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    delay_arbiter_if.slave    req_bus,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic [OCC_W-1:0]  occupancy,
    output logic              busy
);

    logic [N_DELAY-1:0] stg_valid;
    logic [ID_W-1:0]    stg_id   [N_DELAY];
    logic [DATA_W-1:0]  stg_data [N_DELAY];
    logic [ID_W-1:0]    rr_ptr;

    logic [ID_W-1:0]    hi_idx;
    logic [ID_W-1:0]    lo_idx;
    logic               hi_found;
    logic               any_req;
    logic [ID_W-1:0]    grant_id;
    logic [N_REQ-1:0]   grant;
    logic [DATA_W-1:0]  acc_data;
    logic               accept;

    // Find the lowest requester at/above rr_ptr, and the lowest overall for wrap-around.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        any_req  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_bus.req_valid[i]) begin
                any_req = 1'b1;
                lo_idx  = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
    end

    // Issue the one-hot grant and select the accepted payload; reset, hold and flush suppress it.
    always_comb begin
        accept   = !rst && !hold && !flush && any_req;
        grant_id = hi_found ? hi_idx : lo_idx;
        grant    = '0;
        acc_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept && (ID_W'(i) == grant_id)) begin
                grant[i] = 1'b1;
                acc_data = req_bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_bus.req_ready = grant;

    assign out_valid = stg_valid[N_DELAY-1];
    assign out_data  = stg_data[N_DELAY-1];
    assign out_id    = stg_id[N_DELAY-1];
    assign busy      = (occupancy != '0);

    // Control state: stage valids, round-robin pointer and the in-flight count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= '0;
            rr_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            stg_valid <= '0;
            occupancy <= '0;
        end else if (!hold) begin
            for (int s = N_DELAY - 1; s >= 1; s--) begin
                stg_valid[s] <= stg_valid[s-1];
            end
            stg_valid[0] <= accept;
            if (accept) begin
                rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
            case ({accept, out_valid})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Payload and requester tag shift alongside the valids; contents of empty stages are don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_DELAY; s++) begin
                stg_id[s]   <= '0;
                stg_data[s] <= '0;
            end
        end else if (!flush && !hold) begin
            for (int s = N_DELAY - 1; s >= 1; s--) begin
                stg_id[s]   <= stg_id[s-1];
                stg_data[s] <= stg_data[s-1];
            end
            stg_id[0]   <= grant_id;
            stg_data[0] <= acc_data;
        end
    end

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench for delay_arbiter: a 4-deep and a 1-deep instance share
// one stimulus; the selected instance is compared against a queue of
// expected items built from a reference round-robin model.
module tb_delay_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        flush;
    logic [3:0]  req_valid;
    logic [31:0] req_data;

    always #5 clk = ~clk;

    delay_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus_a ();
    delay_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus_b ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_data  = req_data;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_data  = req_data;

    logic       ov_a, ov_b, busy_a, busy_b;
    logic [7:0] od_a, od_b;
    logic [1:0] oi_a, oi_b;
    logic [2:0] occ_a;
    logic [0:0] occ_b;

    delay_arbiter #(.N_REQ(4), .N_DELAY(4), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst), .req_bus(bus_a.slave), .hold(hold), .flush(flush),
        .out_valid(ov_a), .out_data(od_a), .out_id(oi_a), .occupancy(occ_a), .busy(busy_a)
    );

    delay_arbiter #(.N_REQ(4), .N_DELAY(1), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .req_bus(bus_b.slave), .hold(hold), .flush(flush),
        .out_valid(ov_b), .out_data(od_b), .out_id(oi_b), .occupancy(occ_b), .busy(busy_b)
    );

    int         sel;
    int         ndly;
    logic [3:0] rdy;
    logic       ovl;
    logic [7:0] od;
    logic [1:0] oid;
    int         occ;
    logic       bsy;

    always_comb begin
        if (sel != 0) begin
            rdy = bus_b.req_ready; ovl = ov_b; od = od_b; oid = oi_b;
            occ = int'(occ_b); bsy = busy_b;
        end else begin
            rdy = bus_a.req_ready; ovl = ov_a; od = od_a; oid = oi_a;
            occ = int'(occ_a); bsy = busy_a;
        end
    end

    typedef struct {
        int id;
        int data;
        int due;
    } item_t;

    item_t sb[$];
    int    rr;
    int    adv_cnt;
    int    n_tests;
    int    n_fail;

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (rst || hold || flush) return -1;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (rr + k) % 4;
            if (((req_valid >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    // Compare the DUT against the scoreboard, then advance the model over the coming edge.
    task automatic cycle();
        int    g;
        int    exp_rdy;
        int    exp_ov;
        item_t it;
        @(negedge clk);
        g       = exp_grant();
        exp_rdy = (g >= 0) ? (1 << g) : 0;
        check_val("req_ready", int'(rdy), exp_rdy);
        exp_ov = (sb.size() > 0 && sb[0].due == adv_cnt) ? 1 : 0;
        check_val("out_valid", int'(ovl), exp_ov);
        if (exp_ov == 1) begin
            check_val("out_id", int'(oid), sb[0].id);
            check_val("out_data", int'(od), sb[0].data);
        end
        check_val("occupancy", occ, sb.size());
        check_val("busy", int'(bsy), (sb.size() != 0) ? 1 : 0);
        if (!rst) begin
            if (flush) begin
                sb.delete();
            end else if (!hold) begin
                if (exp_ov == 1) void'(sb.pop_front());
                adv_cnt++;
                if (g >= 0) begin
                    it.id   = g;
                    it.data = int'((req_data >> (g * 8)) & 32'hFF);
                    it.due  = adv_cnt + ndly - 1;
                    sb.push_back(it);
                    rr = (g + 1) % 4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and confirm outputs clear without waiting for a clock.
    task automatic async_reset();
        #1 rst = 1'b1;
        #2;
        check_val("rst_out_valid", int'(ovl), 0);
        check_val("rst_busy", int'(bsy), 0);
        check_val("rst_occupancy", occ, 0);
        check_val("rst_req_ready", int'(rdy), 0);
        check_val("rst_out_data", int'(od), 0);
        check_val("rst_out_id", int'(oid), 0);
        sb.delete();
        rr = 0;
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; flush = 1'b0; req_valid = '0; req_data = '0;
        sel = 0; ndly = 4; rr = 0; adv_cnt = 0; n_tests = 0; n_fail = 0;
        #1 rst = 1'b1;
        #1;
        check_val("init_out_valid", int'(ovl), 0);
        check_val("init_occupancy", occ, 0);
        check_val("init_out_data", int'(od), 0);
        repeat (2) cycle();
        rst = 1'b0;

        // single requester 0, payload 0xA5
        req_valid = 4'b0001; req_data = 32'h5A5A_5AA5;
        cycle();
        req_valid = '0;
        repeat (6) cycle();

        // all requesters continuously
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            req_data = $urandom();
            cycle();
        end
        req_valid = '0;
        repeat (5) cycle();

        // two items in flight, then hold for 3 cycles with requests pending
        req_valid = 4'b0011;
        repeat (2) begin
            req_data = $urandom();
            cycle();
        end
        req_valid = 4'b1111; hold = 1'b1;
        repeat (3) cycle();
        hold = 1'b0; req_valid = '0;
        repeat (6) cycle();

        // three items in flight, flush with requester 2 asking
        req_valid = 4'b1111;
        repeat (3) begin
            req_data = $urandom();
            cycle();
        end
        flush = 1'b1; req_valid = 4'b0100;
        cycle();
        flush = 1'b0; req_valid = 4'b1111; req_data = $urandom();
        cycle();
        req_valid = 4'b0100; req_data = $urandom();
        cycle();
        req_valid = '0;
        repeat (6) cycle();

        // full pipe, asynchronous reset, then first grant must search from 0
        req_valid = 4'b1111;
        repeat (7) begin
            req_data = $urandom();
            cycle();
        end
        async_reset();
        cycle();
        rst = 1'b0;
        req_valid = 4'b1010; req_data = $urandom();
        cycle();
        req_valid = '0;
        repeat (5) cycle();

        // single-stage instance, requester 3 only
        rst = 1'b1; sb.delete(); rr = 0; sel = 1; ndly = 1;
        cycle();
        rst = 1'b0;
        req_valid = 4'b1000; req_data = $urandom();
        cycle();
        req_valid = '0;
        repeat (2) cycle();
        req_valid = 4'b1000;
        repeat (3) begin
            req_data = $urandom();
            cycle();
        end
        req_valid = '0;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the delay pipeline (legal range >= 2).
REQ-002 SHALL have parameter N_DELAY, default 4: pipeline depth in clock cycles (legal range >= 1).
REQ-003 SHALL have parameter DATA_W, default 8: payload width in bits.
REQ-004 SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  N_REQ  per-requester request strobe.
REQ-008 req_data  input  N_REQ x DATA_W  per-requester payload, packed.
REQ-009 req_ready  output  N_REQ  one-hot grant; all zero when no grant is issued.
REQ-010 hold  input  1  freezes the pipeline and the arbiter.
REQ-011 flush  input  1  discards all in-flight items.
REQ-012 out_valid  output  1  pipeline output item valid.
REQ-013 out_data  output  DATA_W  payload of the output item.
REQ-014 out_id  output  clog2(N_REQ)  index of the requester that issued the output item.
REQ-015 occupancy  output  clog2(N_DELAY+1)  number of items currently in flight.
REQ-016 busy  output  1  high when occupancy != 0.

Function
REQ-017 Grant SHALL be combinational from req_valid, hold, flush, and the round-robin pointer rr_ptr.
- When hold=0 and flush=0: grant the first asserted req_valid searching upward from rr_ptr, wrapping modulo N_REQ.
- At most one req_ready bit SHALL be high.
REQ-018 An item SHALL be accepted on any rising edge where req_valid[i] & req_ready[i]. It then enters stage 0 with tag id=i.
REQ-019 On each accept, rr_ptr SHALL update to (i+1) mod N_REQ. rr_ptr SHALL NOT change on an edge without an accept.
REQ-020 The pipeline SHALL have N_DELAY stages, each holding {valid, id, data}.
- The out_* outputs SHALL be driven directly from stage N_DELAY-1.
- Item accepted at edge E: out_valid=1 with its out_data/out_id during the cycle after edge E+N_DELAY-1, counting only edges with hold=0.
REQ-021 Advance on an edge with hold=0:
- Every stage SHALL shift one place.
- Stage 0 SHALL load the accepted item, or valid=0 if there is no accept.
- Each item SHALL appear on out_valid for exactly one cycle.
REQ-022 hold=1: all stages, rr_ptr, and occupancy SHALL keep their values, and req_ready SHALL be all zero.
REQ-023 flush=1 on an edge: all stage valid bits SHALL clear, occupancy SHALL become 0, and no accept SHALL occur (req_ready all zero).
- flush SHALL take priority over hold.
- rr_ptr SHALL be preserved.
REQ-024 Occupancy on an advancing edge SHALL be incremented by an accept and decremented by out_valid=1.
- Both events on the same edge SHALL leave it unchanged.
- It SHALL never exceed N_DELAY or go below 0.
REQ-025 Requesters not granted SHALL hold req_valid/req_data stable. The block SHALL NOT buffer ungranted requests.
REQ-026 With N_DELAY=1, an item accepted at edge E SHALL be on out_* in the cycle immediately following E.
REQ-027 Stage data and id of invalid stages are don't-care. out_data/out_id SHALL be qualified only by out_valid.

Reset
REQ-028 While rst=1, all of the following SHALL hold immediately, independent of clk:
- All stage valid bits = 0, stage data/id = 0.
- rr_ptr = 0.
- occupancy = 0, busy = 0, out_valid = 0, out_data = 0, out_id = 0.
REQ-029 While rst=1, req_ready SHALL be all zero.
REQ-030 If rst asserts mid-operation, in-flight items SHALL be lost with no output pulse. The first grant after release SHALL search from requester 0.

Verification
REQ-031 Single requester: N_REQ=4, N_DELAY=4; req_valid=0001, data 0xA5 held one cycle.
- Expect out_valid=1, out_data=0xA5, out_id=0 exactly 4 edges after accept.
- Expect occupancy 1 during transit, 0 after the pulse.
REQ-032 Round-robin: req_valid=1111 held continuously.
- Expect grants 0,1,2,3,0,... on consecutive edges.
- Expect outputs in the same id order from edge 4, with occupancy steady at 4.
REQ-033 Hold: assert hold for 3 cycles while 2 items are in flight.
- Expect no out_valid pulses and req_ready=0 during hold.
- Expect the items to emerge 3 cycles later than without hold, with occupancy unchanged during hold.
REQ-034 Flush: flush=1 together with req_valid=0100 while 3 items are in flight.
- Expect no accept, occupancy=0, and no out_valid for those items.
- Expect rr_ptr unchanged, so the next grant goes to requester 2.
REQ-035 Reset mid-run: assert rst asynchronously between edges with 4 items in flight.
- Expect out_valid, busy, and occupancy to go to 0 before the next edge.
- After release with req_valid=1010, expect the first grant to be requester 1.
REQ-036 Boundary: N_DELAY=1, requester 3 only.
- Expect output in the cycle after accept, with occupancy returning to 0 on that same advancing edge if no new accept.
- Simultaneous accept and output SHALL hold occupancy at 1.
